// File: rtl/seq_detect_ctrl.sv
// Run controller for a serial PAT_W-bit sequence detector: programmable pattern,
// overlap mode, start/done framed runs of run_len bits, saturating match count.
module seq_detect_ctrl #(
    parameter int PAT_W = 4,
    parameter int LEN_W = 8,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_load,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic             cfg_overlap,
    input  logic             start,
    input  logic [LEN_W-1:0] run_len,
    input  logic             x,
    input  logic             x_valid,
    output logic             z,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] match_count
);
    localparam int FW = $clog2(PAT_W + 1);

    // Default pattern is the low PAT_W bits of ...1010 (odd bit positions set).
    function automatic logic [PAT_W-1:0] def_pat();
        logic [PAT_W-1:0] p;
        for (int i = 0; i < PAT_W; i++) p[i] = 1'(i % 2);
        return p;
    endfunction
    localparam logic [PAT_W-1:0] PAT_RST = def_pat();

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [PAT_W-1:0] pattern;
    logic             overlap;
    logic [PAT_W-1:0] hist;
    logic [FW-1:0]    fill;
    logic [LEN_W-1:0] remaining;

    logic [PAT_W-1:0] new_hist;
    logic             hit;
    logic [FW-1:0]    fill_inc;

    always_comb begin
        new_hist = {hist[PAT_W-2:0], x};
        hit      = (fill >= FW'(PAT_W - 1)) && (new_hist == pattern);
        fill_inc = (fill == FW'(PAT_W)) ? fill : fill + FW'(1);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            pattern     <= PAT_RST;
            overlap     <= 1'b0;
            hist        <= '0;
            fill        <= '0;
            remaining   <= '0;
            z           <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
            match_count <= '0;
        end else begin
            case (state)
                IDLE: begin
                    z    <= 1'b0;
                    done <= 1'b0;
                    if (cfg_load) begin
                        pattern <= cfg_pattern;
                        overlap <= cfg_overlap;
                    end
                    if (start) begin
                        match_count <= '0;
                        if (run_len != '0) begin
                            hist      <= '0;
                            fill      <= '0;
                            remaining <= run_len;
                            busy      <= 1'b1;
                            state     <= RUN;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (x_valid) begin
                        z <= hit;
                        if (hit && match_count != '1)
                            match_count <= match_count + CNT_W'(1);
                        // Non-overlap: a match consumes its bits, so refill from scratch.
                        fill      <= (hit && !overlap) ? '0 : fill_inc;
                        hist      <= new_hist;
                        remaining <= remaining - LEN_W'(1);
                        if (remaining == LEN_W'(1)) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end else begin
                        z <= 1'b0;
                    end
                end
                DONE: begin
                    z     <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_detect_ctrl.sv
// Bench for seq_detect_ctrl: two instances (CNT_W=8 and CNT_W=2) share stimulus and
// are compared every cycle against a window-matching reference model.
module tb_seq_detect_ctrl;
    localparam int P = 4;

    logic         clk = 1'b0;
    logic         reset, cfg_load, cfg_overlap, start, x, x_valid;
    logic [P-1:0] cfg_pattern;
    logic [7:0]   run_len;
    logic         z, busy, done, z2, busy2, done2;
    logic [7:0]   match_count;
    logic [1:0]   mc2;

    int checks = 0;
    int failures = 0;

    logic [P-1:0] m_pat;
    logic         m_ovl;
    int           m_cnt;

    seq_detect_ctrl #(.PAT_W(P), .LEN_W(8), .CNT_W(8)) dut (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .start(start), .run_len(run_len), .x(x),
        .x_valid(x_valid), .z(z), .busy(busy), .done(done), .match_count(match_count)
    );

    seq_detect_ctrl #(.PAT_W(P), .LEN_W(8), .CNT_W(2)) dut2 (
        .clk(clk), .reset(reset), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
        .cfg_overlap(cfg_overlap), .start(start), .run_len(run_len), .x(x),
        .x_valid(x_valid), .z(z2), .busy(busy2), .done(done2), .match_count(mc2)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic chk_all(input string tag, input logic ez, input logic eb, input logic ed);
        chk({tag, "_z"}, 32'(z), 32'(ez));
        chk({tag, "_busy"}, 32'(busy), 32'(eb));
        chk({tag, "_done"}, 32'(done), 32'(ed));
        chk({tag, "_cnt"}, 32'(match_count), (m_cnt > 255) ? 255 : m_cnt);
        chk({tag, "_z2"}, 32'(z2), 32'(ez));
        chk({tag, "_busy2"}, 32'(busy2), 32'(eb));
        chk({tag, "_done2"}, 32'(done2), 32'(ed));
        chk({tag, "_cnt2"}, 32'(mc2), (m_cnt > 3) ? 3 : m_cnt);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        m_cnt = 0;
        m_pat = 4'b1010;
        m_ovl = 1'b0;
        chk_all("rst", 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    // Inputs that must be ignored while a run is in progress.
    task automatic drive_noise(input bit fixed);
        cfg_load    = fixed ? 1'b1 : 1'($urandom);
        cfg_pattern = fixed ? 4'b0110 : P'($urandom);
        cfg_overlap = fixed ? 1'b1 : 1'($urandom);
        start       = 1'($urandom);
        run_len     = 8'($urandom);
    endtask

    // One run: first bit is bits[len-1]. Gaps of gmin..gmax invalid cycles precede each bit.
    task automatic do_run(input bit ld, input logic [P-1:0] pat, input bit ovl, input int len,
                          input logic [31:0] bits, input int gmin, input int gmax, input bit fixed_noise);
        logic q[$];
        int   last;
        int   g;
        logic b, hit;
        logic [P-1:0] w;
        last = -100;
        cfg_load = ld; cfg_pattern = pat; cfg_overlap = ovl;
        start = 1'b1; run_len = 8'(len);
        x_valid = 1'($urandom); x = 1'($urandom);
        if (ld) begin m_pat = pat; m_ovl = ovl; end
        tick();
        m_cnt = 0;
        chk_all("start", 1'b0, len != 0, len == 0);
        cfg_load = 1'b0; start = 1'b0; x_valid = 1'b0;
        if (len == 0) begin
            tick();
            chk_all("zl_idle", 1'b0, 1'b0, 1'b0);
            return;
        end
        for (int i = 0; i < len; i++) begin
            g = $urandom_range(gmax, gmin);
            repeat (g) begin
                drive_noise(fixed_noise);
                x_valid = 1'b0; x = 1'($urandom);
                tick();
                chk_all("gap", 1'b0, 1'b1, 1'b0);
            end
            drive_noise(fixed_noise);
            b = bits[len-1-i];
            x_valid = 1'b1; x = b;
            tick();
            q.push_back(b);
            hit = 1'b0;
            if (i >= P - 1) begin
                w = {q[i-3], q[i-2], q[i-1], q[i]};
                hit = (w == m_pat) && (m_ovl || (i - last >= P));
            end
            if (hit) begin last = i; m_cnt++; end
            chk_all("bit", hit, i != len - 1, i == len - 1);
        end
        // done cycle: start/config here must not be taken
        drive_noise(1'b0);
        x_valid = 1'b1;
        tick();
        chk_all("post", 1'b0, 1'b0, 1'b0);
        start = 1'b0; cfg_load = 1'b0; x_valid = 1'b0;
    endtask

    initial begin
        int len;
        reset = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_overlap = 1'b0;
        start = 1'b0; run_len = '0; x = 1'b0; x_valid = 1'b0;
        m_cnt = 0;
        do_reset();

        // default config, 101010
        do_run(1'b0, 4'b0, 1'b0, 6, 32'b101010, 0, 0, 1'b0);
        chk("t1_cnt", 32'(match_count), 1);

        // overlap vs non-overlap on 1010101
        do_run(1'b1, 4'b1010, 1'b1, 7, 32'b1010101, 0, 0, 1'b0);
        chk("t2_ovl_cnt", 32'(match_count), 2);
        do_run(1'b1, 4'b1010, 1'b0, 7, 32'b1010101, 0, 0, 1'b0);
        chk("t2_novl_cnt", 32'(match_count), 1);

        // bits separated by 3 invalid cycles
        do_run(1'b0, 4'b0, 1'b0, 4, 32'b1010, 3, 3, 1'b0);
        chk("t3_cnt", 32'(match_count), 1);

        // saturation: 10 ones, 1111 overlap -> 7 raw matches
        do_run(1'b1, 4'b1111, 1'b1, 10, 32'h3FF, 0, 0, 1'b0);
        chk("t4_cnt8", 32'(match_count), 7);
        chk("t4_cnt2", 32'(mc2), 3);

        // zero-length run, then cfg_load 0110 during a run is ignored
        do_run(1'b1, 4'b1010, 1'b0, 0, 32'b0, 0, 0, 1'b0);
        chk("t5_zl_cnt", 32'(match_count), 0);
        do_run(1'b0, 4'b0, 1'b0, 6, 32'b011010, 0, 1, 1'b1);
        do_run(1'b0, 4'b0, 1'b0, 4, 32'b1010, 0, 0, 1'b0);
        chk("t5_keep_cnt", 32'(match_count), 1);

        // abort mid-run with a non-default config loaded; reset restores 1010/non-overlap
        cfg_load = 1'b1; cfg_pattern = 4'b0110; cfg_overlap = 1'b1;
        start = 1'b1; run_len = 8'd8;
        tick();
        cfg_load = 1'b0; start = 1'b0; x_valid = 1'b1; x = 1'b1;
        tick();
        x = 1'b0;
        tick();
        x_valid = 1'b0;
        do_reset();
        do_run(1'b0, 4'b0, 1'b0, 4, 32'b1010, 0, 0, 1'b0);
        chk("t6_cnt", 32'(match_count), 1);

        // randomized runs
        for (int r = 0; r < 40; r++) begin
            len = $urandom_range(20, 0);
            do_run(1'($urandom_range(3, 0) != 0), P'($urandom_range(15, 0)), 1'($urandom),
                   len, ($urandom_range(1, 0) != 0) ? 32'($urandom) : 32'h5555_5555,
                   0, 2, 1'b0);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/seq_detect_ctrl.md
# seq_detect_ctrl

Run controller for the serial 4-bit sequence detector. It holds a programmable target pattern and the overlap/non-overlap mode, and frames a bounded run of serial bits with a start/done handshake. During the run it drives the per-match pulse and accumulates a saturating match count. It sits between the stimulus/config source and downstream logic that consumes `z` and the per-run count.

## Interface
Parameters:
- `PAT_W`, 4, pattern length in bits (≥2)
- `LEN_W`, 8, width of run-length field
- `CNT_W`, 8, width of match counter (saturating)

Ports:
- `clk`  in  1  single clock; all logic on rising edge
- `reset`  in  1  synchronous, active-high reset
- `cfg_load`  in  1  capture `cfg_pattern`/`cfg_overlap`; honoured only in IDLE
- `cfg_pattern`  in  PAT_W  target pattern, MSB = oldest bit
- `cfg_overlap`  in  1  1 = overlapping detection, 0 = non-overlapping
- `start`  in  1  begin a run; honoured only in IDLE
- `run_len`  in  LEN_W  number of valid bits in the run, sampled with `start`
- `x`  in  1  serial data bit
- `x_valid`  in  1  `x` is valid this cycle; consumed only in RUN
- `z`  out  1  one-cycle match pulse
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle run-complete pulse
- `match_count`  out  CNT_W  matches in current/last run

## Operation
- Reset values:
  - outputs: `z`=0, `busy`=0, `done`=0, `match_count`=0.
  - state: IDLE; pattern register = 1010 (low PAT_W bits of …1010); overlap register = 0.
  - internal: history cleared, fill counter 0, remaining counter 0.
- States: IDLE, RUN, DONE.
- IDLE:
  - `cfg_load`=1 loads the pattern and overlap registers.
  - `start`=1 with `run_len`≠0: clears `match_count`, history and fill; loads remaining = `run_len`; next state RUN.
  - `start`=1 with `run_len`=0: clears `match_count`; next state DONE.
  - `start` and `cfg_load` in the same cycle: the config is loaded first and applies to this run.
- RUN, on each cycle with `x_valid`=1:
  - new_hist = {history[PAT_W-2:0], x}.
  - match = (fill ≥ PAT_W-1) && new_hist == pattern.
  - If match: `z`←1 and `match_count` increments, saturating at 2^CNT_W−1.
  - Non-overlap mode: a match sets fill←0. Otherwise fill←min(fill+1, PAT_W).
  - Overlap mode: fill←min(fill+1, PAT_W) always.
  - history←new_hist; remaining decrements.
  - When remaining reaches 0 (i.e. the last bit is consumed), next state is DONE.
- RUN, on cycles with `x_valid`=0: no shift, no count change, `z`←0.
- `cfg_load` and `start` are ignored outside IDLE.
- DONE: `done`=1 for exactly one cycle, then IDLE. `match_count` holds until the next accepted `start`.
- `reset` asserted in any state aborts the run. All registers return to reset values at that edge, including the configuration, which reverts to the defaults.

## Timing
- `start` sampled at edge E: `busy`=1 from E. The first bit that can be consumed is at edge E+1; `x_valid` in the `start` cycle is ignored.
- Bit consumed at edge k:
  - `z` is high during cycle k→k+1, i.e. one cycle of latency, registered.
  - `match_count` reflects that bit from the same cycle.
- Last bit consumed at edge L:
  - `busy`=0, `done`=1 and the final `z` are all visible in the same cycle after L.
  - `match_count` in that cycle already includes the final bit.
- Zero-length run: `done` is visible in the cycle after the `start` edge.
- Back-to-back runs: a `start` asserted during the `done` cycle is ignored. The earliest accepted `start` is one cycle after `done`.
- `z` is never high in IDLE or DONE except as the final-bit pulse coinciding with `done`.

## Test plan
- Defaults after reset (1010, non-overlap): `start`, `run_len`=6, bits 1,0,1,0,1,0 on consecutive cycles -> single `z` after the 4th bit; `done` after the 6th; `match_count`=1.
- `cfg_load` 1010 with overlap=1, `run_len`=7, bits 1010101 -> `z` after bits 4 and 6; `match_count`=2. The same stream in non-overlap mode -> `match_count`=1.
- Stream 1,0,1,0 with `x_valid` low for 3 cycles between each bit -> exactly one `z`, after the 4th valid bit. `busy` stays high until `done`, which follows the 4th valid bit.
- CNT_W=2, pattern 1111, overlap, 10 ones -> 7 raw matches; `match_count` saturates at 3 while `z` still pulses 7 times.
- `run_len`=0 -> `done` in the cycle after `start` with `match_count`=0. `cfg_load` of 0110 during RUN is ignored: the next run still detects 1010.
- `reset` pulsed mid-run after 2 bits -> the next cycle shows all outputs 0 and pattern = 1010. A fresh run of 1010 yields `match_count`=1.
